seq_mag_cmp: RTL and testbench

Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. It compares CHUNK bits per clock, MSB-first, and terminates early at the first differing chunk. It supports unsigned and two's-complement signed modes through a start/busy/done handshake. It supersedes the single-bit combinational comparator wherever wide operands must be compared without a WIDTH-deep combinational carry chain.

---
 rtl/seq_mag_cmp.sv | 123 ++++++++++++
 tb/tb_seq_mag_cmp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_cmp.sv
// Purpose : multi-cycle magnitude comparator for WIDTH-bit operands. It compares
//           CHUNK bits per clock, MSB-first, and stops at the first chunk that differs.
// Latency : 1..NCHUNK cycles from the acceptance edge to done; equal operands take longest.
// Backpr. : start is sampled only in IDLE. While busy or done, start is ignored.
// Ports   : clk, rst (async, active-high); start/a/b/signed_mode request inputs;
//           busy (RUN), done (1-cycle pulse), a_lt_b/a_gt_b/a_eq_b registered result flags.
module seq_mag_cmp #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_gt_b,
    output logic             a_eq_b
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]        flags_q, flags_d;   // {lt, gt, eq}
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  a_sh, b_sh;
    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic              last_chunk;

    // Shift the current chunk up to the MSB end so the slice below has a
    // constant position; this avoids a variable-base part-select.
    assign a_sh       = a_q << (idx_q * CHUNK);
    assign b_sh       = b_q << (idx_q * CHUNK);
    assign a_chunk    = a_sh[WIDTH-1 -: CHUNK];
    assign b_chunk    = b_sh[WIDTH-1 -: CHUNK];
    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Flipping both MSBs maps two's-complement onto offset binary,
                    // so the rest of the compare is purely unsigned.
                    a_d            = a;
                    a_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
                    b_d            = b;
                    b_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
                    idx_d          = '0;
                    flags_d        = 3'b000;
                    state_d        = S_RUN;
                end
            end
            S_RUN: begin
                if (a_chunk > b_chunk) begin
                    flags_d = 3'b010;
                    state_d = S_DONE;
                end else if (a_chunk < b_chunk) begin
                    flags_d = 3'b100;
                    state_d = S_DONE;
                end else if (last_chunk) begin
                    flags_d = 3'b001;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // busy/done are decoded from the next state so they come straight off flops.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_lt_b = flags_q[2];
    assign a_gt_b = flags_q[1];
    assign a_eq_b = flags_q[0];

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Bench for seq_mag_cmp: three instances (CHUNK = 1, 4, 16) share one set of inputs.
// Stimulus pushes expected {flags, latency} per instance; a negedge monitor pops and compares.
module tb_seq_mag_cmp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        signed_mode = 1'b0;
    logic [2:0]  busy_w, done_w, lt_w, gt_w, eq_w;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] fl;
        int         k;
        int         acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [2:0] last_fl [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        seq_mag_cmp #(
            .WIDTH(16),
            .CHUNK((gi == 0) ? 1 : ((gi == 1) ? 4 : 16))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .a          (a),
            .b          (b),
            .signed_mode(signed_mode),
            .busy       (busy_w[gi]),
            .done       (done_w[gi]),
            .a_lt_b     (lt_w[gi]),
            .a_gt_b     (gt_w[gi]),
            .a_eq_b     (eq_w[gi])
        );
    end

    function automatic int ch_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
    endfunction

    // Reference: plain integer compare on the operand values.
    function automatic logic [2:0] ref_flags(input logic [15:0] ra, input logic [15:0] rb, input logic rs);
        int ia, ib;
        ia = rs ? {{16{ra[15]}}, ra} : {16'h0000, ra};
        ib = rs ? {{16{rb[15]}}, rb} : {16'h0000, rb};
        if (ia < ib) return 3'b100;
        if (ia > ib) return 3'b010;
        return 3'b001;
    endfunction

    // Reference latency: 1-based position of the first differing chunk from the MSB.
    function automatic int ref_k(input logic [15:0] ra, input logic [15:0] rb, input int ch);
        int x, n;
        x = ra ^ rb;
        n = 16 / ch;
        for (int j = 0; j < n; j++) begin
            if (((x >> (16 - (j + 1) * ch)) & ((1 << ch) - 1)) != 0) return j + 1;
        end
        return n;
    endfunction

    function automatic void push_exp(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic chk(input bit ok, input string nm, input int inst, input int act, input int expv);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s chunk=%0d: got %0d required %0d (t=%0t)", nm, ch_of(inst), act, expv, $time);
        end
    endtask

    // Monitor: every negedge, check reset values, in-flight flags, retention, and completions.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                chk({busy_w[i], done_w[i], lt_w[i], gt_w[i], eq_w[i]} == 5'b0, "reset_outputs", i,
                    int'({busy_w[i], done_w[i], lt_w[i], gt_w[i], eq_w[i]}), 0);
                last_fl[i] = 3'b000;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [2:0] fl;
                exp_t       e;
                fl = {lt_w[i], gt_w[i], eq_w[i]};
                if (done_w[i]) begin
                    if (qsize(i) == 0) begin
                        chk(1'b0, "unexpected_done", i, 1, 0);
                    end else begin
                        e = pop_exp(i);
                        chk(fl == e.fl, "flags", i, int'(fl), int'(e.fl));
                        chk(cyc - e.acc == e.k, "latency", i, cyc - e.acc, e.k);
                        chk(busy_w[i] == 1'b0, "busy_in_done", i, int'(busy_w[i]), 0);
                        last_fl[i] = e.fl;
                    end
                end else if (busy_w[i]) begin
                    chk(fl == 3'b000, "flags_in_run", i, int'(fl), 0);
                end else begin
                    chk(fl == last_fl[i], "flags_idle", i, int'(fl), int'(last_fl[i]));
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(busy_w == 3'b000 && done_w == 3'b000) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk(1'b0, "idle_timeout", 1, n, 200);
    endtask

    task automatic push_all(input logic [15:0] ra, input logic [15:0] rb, input logic rs, input int acc);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.fl  = ref_flags(ra, rb, rs);
            e.k   = ref_k(ra, rb, ch_of(i));
            e.acc = acc;
            push_exp(i, e);
        end
    endtask

    // One request; optional second start pulse during RUN with scrambled operands.
    task automatic issue(input logic [15:0] ra, input logic [15:0] rb, input logic rs, input bit repulse);
        wait_idle();
        a = ra; b = rb; signed_mode = rs; start = 1'b1;
        push_all(ra, rb, rs, cyc + 1);
        @(negedge clk);
        start = repulse;
        a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic hold_start(input logic [15:0] ra, input logic [15:0] rb, input logic rs);
        exp_t e;
        int   c, p;
        wait_idle();
        a = ra; b = rb; signed_mode = rs; start = 1'b1;
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            p = ref_k(ra, rb, ch_of(i)) + 2;
            for (int n = 0; n * p <= 19; n++) begin
                e.fl  = ref_flags(ra, rb, rs);
                e.k   = p - 2;
                e.acc = c + 1 + n * p;
                push_exp(i, e);
            end
        end
        repeat (20) @(negedge clk);
        start = 1'b0;
    endtask

    logic [15:0] dir_a [6] = '{16'h8000, 16'h1234, 16'hABCD, 16'h8000, 16'h8000, 16'hFFFF};
    logic [15:0] dir_b [6] = '{16'h7FFF, 16'h1235, 16'hABCD, 16'h0001, 16'h0001, 16'hFFFE};
    logic        dir_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [15:0] ra, rb;
        int          mode;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) issue(dir_a[i], dir_b[i], dir_s[i], i == 1);

        hold_start(16'h1234, 16'h1235, 1'b0);

        // Reset in the 2nd RUN cycle of an equal-operand compare.
        wait_idle();
        a = 16'h5A5A; b = 16'h5A5A; signed_mode = 1'b0; start = 1'b1;
        push_all(16'h5A5A, 16'h5A5A, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(16'h00F0, 16'h00E0, 1'b0, 1'b0);

        // Reset with random inputs toggling.
        wait_idle();
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom); a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Randomised sweep in both modes with operands biased towards late differences.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 550; n++) begin
                ra   = 16'($urandom);
                mode = $urandom_range(2);
                if (mode == 0)      rb = 16'($urandom);
                else if (mode == 1) rb = ra;
                else                rb = ra ^ (16'h0001 << $urandom_range(15));
                issue(ra, rb, 1'(s), 1'($urandom_range(1)));
            end
        end

        wait_idle();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk(qsize(i) == 0, "leftover_expected", i, qsize(i), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
